// File: rtl/alu_result_display.sv
// alu_result_display: sequential double-dabble of ALU results onto a scanned 4-digit 7-segment display
module alu_result_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  intResult,
   input  logic        resultValid,
   output logic        busy,
   output logic [11:0] bcdValue,
   output logic [3:0]  anode,
   output logic [6:0]  segment,
   output logic        dp
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
   localparam logic [6:0] BLANK = 7'b1111111;
   typedef enum logic {IDLE, CONVERT} stateType;
   stateType state;
   logic [19:0] shiftReg, adjusted, shifted;
   logic [2:0] iterCnt;
   logic [CW-1:0] refreshCnt;
   logic [1:0] digitSel, nextSel;
   logic [6:0] nextSeg;
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction
   function automatic logic [6:0] segOf(input logic [3:0] n);
      case (n)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return BLANK;
      endcase
   endfunction
   // Segments are computed for the digit being selected on this edge so anode and segment switch together
   always_comb begin
      adjusted = {add3(shiftReg[19:16]), add3(shiftReg[15:12]), add3(shiftReg[11:8]), shiftReg[7:0]};
      shifted  = adjusted << 1;
      nextSel  = (refreshCnt == LAST) ? digitSel + 2'd1 : digitSel;
      nextSeg  = (nextSel == 2'd0) ? segOf(bcdValue[3:0]) :
                 (nextSel == 2'd1) ? ((bcdValue[11:4] == 8'd0) ? BLANK : segOf(bcdValue[7:4])) :
                 (nextSel == 2'd2) ? ((bcdValue[11:8] == 4'd0) ? BLANK : segOf(bcdValue[11:8])) :
                 BLANK;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         bcdValue <= 12'h000;
         shiftReg <= 20'd0;
         iterCnt  <= 3'd0;
      end else if (state == IDLE) begin
         if (resultValid) begin
            shiftReg <= {12'd0, intResult};
            iterCnt  <= 3'd0;
            state    <= CONVERT;
            busy     <= 1'b1;
         end
      end else begin
         shiftReg <= shifted;
         iterCnt  <= iterCnt + 3'd1;
         if (iterCnt == 3'd7) begin
            bcdValue <= shifted[19:8];
            state    <= IDLE;
            busy     <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         refreshCnt <= '0;
         digitSel   <= 2'd0;
         anode      <= 4'b1110;
         segment    <= 7'b1000000;
      end else begin
         refreshCnt <= (refreshCnt == LAST) ? '0 : refreshCnt + CW'(1);
         digitSel   <= nextSel;
         anode      <= ~(4'b0001 << nextSel);
         segment    <= nextSeg;
      end
   end
   assign dp = 1'b1;
endmodule

// File: tb/tb_alu_result_display.sv
// tb_alu_result_display: directed and randomized checks against a decimal-arithmetic reference model
module tb_alu_result_display;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] intResult = 8'd0;
   logic resultValid = 1'b0;
   logic busy, dp;
   logic [11:0] bcdValue;
   logic [3:0] anode;
   logic [6:0] segment;
   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int modelVal = 0;
   logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   alu_result_display #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .intResult(intResult), .resultValid(resultValid),
      .busy(busy), .bcdValue(bcdValue), .anode(anode), .segment(segment), .dp(dp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [11:0] toBcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction

   // Leading-zero suppression: a position is lit only if the number has that many decimal digits
   function automatic logic [6:0] expSeg(input int v, input int p);
      int d;
      bit show;
      d = (p == 0) ? v % 10 : (p == 1) ? (v / 10) % 10 : (v / 100) % 10;
      show = (p == 0) || (p == 1 && v >= 10) || (p == 2 && v >= 100);
      return show ? segTab[d] : 7'b1111111;
   endfunction

   task automatic scanCheck();
      int p;
      logic [3:0] expAnode;
      p = (cyc / 4) % 4;
      expAnode = ~(4'b0001 << p);
      chk("anode", 32'(anode), 32'(expAnode));
      chk("segment", 32'(segment), 32'(expSeg(modelVal, p)));
   endtask

   task automatic scanRun(input int n);
      repeat (n) begin
         tick();
         scanCheck();
      end
   endtask

   task automatic doConvert(input int v, input bit noise);
      logic [11:0] prev;
      prev = toBcd(modelVal);
      intResult = 8'(v);
      resultValid = 1'b1;
      tick();
      chk("busy_T", 32'(busy), 32'd1);
      chk("bcd_T", 32'(bcdValue), 32'(prev));
      for (int i = 1; i <= 8; i++) begin
         resultValid = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
         intResult = 8'($urandom);
         tick();
         if (i < 8) begin
            chk("busy_mid", 32'(busy), 32'd1);
            chk("bcd_hold", 32'(bcdValue), 32'(prev));
         end else begin
            chk("busy_done", 32'(busy), 32'd0);
            chk("bcd_done", 32'(bcdValue), 32'(toBcd(v)));
         end
      end
      resultValid = 1'b0;
      modelVal = v;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bcd", 32'(bcdValue), 32'h000);
      chk("rst_anode", 32'(anode), 32'b1110);
      chk("rst_segment", 32'(segment), 32'b1000000);
      chk("rst_dp", 32'(dp), 32'd1);
      rst = 1'b0;
      scanRun(16);

      doConvert(255, 1'b0);
      scanRun(17);
      doConvert(100, 1'b0);
      scanRun(17);
      doConvert(7, 1'b0);
      scanRun(17);

      intResult = 8'd42;
      resultValid = 1'b1;
      tick();
      chk("b42_busy_T", 32'(busy), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         resultValid = (i == 3 || i == 8);
         intResult = 8'd99;
         tick();
         if (i < 8) chk("b42_busy", 32'(busy), 32'd1);
         else begin
            chk("b42_busy_done", 32'(busy), 32'd0);
            chk("b42_bcd", 32'(bcdValue), 32'h042);
         end
      end
      resultValid = 1'b0;
      modelVal = 42;
      doConvert(99, 1'b0);
      scanRun(17);

      doConvert(255, 1'b0);
      intResult = 8'd13;
      resultValid = 1'b1;
      tick();
      resultValid = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_bcd", 32'(bcdValue), 32'h000);
      chk("abort_anode", 32'(anode), 32'b1110);
      rst = 1'b0;
      modelVal = 0;
      repeat (12) begin
         tick();
         chk("abort_busy_after", 32'(busy), 32'd0);
         chk("abort_bcd_after", 32'(bcdValue), 32'h000);
      end
      scanRun(16);

      for (int v = 0; v < 256; v++) begin
         repeat ($urandom_range(0, 3)) begin
            intResult = 8'($urandom);
            tick();
         end
         doConvert(v, 1'b1);
         if (v % 64 == 0) scanRun(16);
      end
      scanRun(16);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
